// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core: opcode encodings, default ROB geometry,
// the ROB entry record and opcode classification helpers.
package tomasulo_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int ROB_IDX_W = 3;
    localparam int DATA_W    = 16;
    localparam int REG_W     = 4;

    localparam logic [3:0] FUNC_ADD   = 4'b0000;
    localparam logic [3:0] FUNC_SUB   = 4'b0001;
    localparam logic [3:0] FUNC_MUL   = 4'b0010;
    localparam logic [3:0] FUNC_DIV   = 4'b0011;
    localparam logic [3:0] FUNC_LOAD  = 4'b0100;
    localparam logic [3:0] FUNC_STORE = 4'b0101;
    localparam logic [3:0] FUNC_BEQ   = 4'b0110;
    localparam logic [3:0] FUNC_BNE   = 4'b0111;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              mispredict;
        logic [3:0]        func;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

    // Arithmetic ops and loads update the register bank; stores, branches and
    // the undefined 1xxx codes do not.
    function automatic logic writes_reg(input logic [3:0] func);
        return func <= FUNC_LOAD;
    endfunction

    function automatic logic is_branch(input logic [3:0] func);
        return (func == FUNC_BEQ) || (func == FUNC_BNE);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit stage: hands out ROB indices at dispatch, captures CDB results,
// retires the head entry in program order and flushes on a mispredicted branch.
module reorder_buffer #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [3:0]        alloc_func,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              cdb_valid,
    input  logic [IDX_W-1:0]  cdb_rob_ind,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_mispredict,
    input  logic [IDX_W-1:0]  lookup_idx,
    output logic              lookup_ready,
    output logic [DATA_W-1:0] lookup_data,
    output logic              commit_valid,
    output logic              commit_we,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic [IDX_W-1:0]  commit_rob_ind,
    output logic              flush,
    output logic [IDX_W:0]    count
);

    import tomasulo_pkg::writes_reg;
    import tomasulo_pkg::is_branch;

    localparam int CW = IDX_W + 1;
    localparam logic [IDX_W:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  misp_q;
    logic [3:0]        func_q [DEPTH];
    logic [REG_W-1:0]  rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;

    logic              commit_valid_q;
    logic              commit_we_q;
    logic [REG_W-1:0]  commit_rd_q;
    logic [DATA_W-1:0] commit_data_q;
    logic [IDX_W-1:0]  commit_rob_ind_q;
    logic              flush_q;

    logic commit_fire;
    logic flush_now;
    logic alloc_rdy;
    logic alloc_fire;
    logic cdb_wr;

    // Dispatch handshake: an entry is taken on a rising edge where alloc_valid and
    // alloc_ready are both high; alloc_idx names that entry. alloc_ready never
    // depends on alloc_valid, and a slot freed by commit is reusable only next cycle.
    always_comb begin
        commit_fire = busy_q[head_q] && done_q[head_q];
        flush_now   = commit_fire && is_branch(func_q[head_q]) && misp_q[head_q];
        alloc_rdy   = (count_q < FULL_CNT) && !flush_now;
        alloc_fire  = alloc_valid && alloc_rdy;
        cdb_wr      = cdb_valid && busy_q[cdb_rob_ind] && !flush_now;

        head_d  = commit_fire ? head_q + IDX_W'(1) : head_q;
        tail_d  = alloc_fire ? tail_q + IDX_W'(1) : tail_q;
        count_d = count_q + CW'(alloc_fire) - CW'(commit_fire);
        if (flush_now) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // A stored result wins over a same-cycle CDB broadcast to the same entry.
    always_comb begin
        lookup_ready = 1'b0;
        lookup_data  = '0;
        if (done_q[lookup_idx]) begin
            lookup_ready = 1'b1;
            lookup_data  = data_q[lookup_idx];
        end else if (cdb_valid && (cdb_rob_ind == lookup_idx)) begin
            lookup_ready = 1'b1;
            lookup_data  = cdb_data;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            done_q  <= '0;
            misp_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                func_q[i] <= '0;
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (flush_now) begin
                busy_q <= '0;
                done_q <= '0;
                misp_q <= '0;
            end else begin
                if (cdb_wr) begin
                    done_q[cdb_rob_ind] <= 1'b1;
                    data_q[cdb_rob_ind] <= cdb_data;
                    if (is_branch(func_q[cdb_rob_ind])) begin
                        misp_q[cdb_rob_ind] <= cdb_mispredict;
                    end
                end
                // The tail slot is never busy while allocation is allowed, so
                // this cannot collide with the CDB write above.
                if (alloc_fire) begin
                    busy_q[tail_q] <= 1'b1;
                    done_q[tail_q] <= 1'b0;
                    misp_q[tail_q] <= 1'b0;
                    func_q[tail_q] <= alloc_func;
                    rd_q[tail_q]   <= alloc_rd;
                end
                if (commit_fire) begin
                    busy_q[head_q] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid_q   <= 1'b0;
            commit_we_q      <= 1'b0;
            commit_rd_q      <= '0;
            commit_data_q    <= '0;
            commit_rob_ind_q <= '0;
            flush_q          <= 1'b0;
        end else begin
            commit_valid_q <= commit_fire;
            commit_we_q    <= commit_fire && writes_reg(func_q[head_q]) && !flush_now;
            flush_q        <= flush_now;
            if (commit_fire) begin
                commit_rd_q      <= rd_q[head_q];
                commit_data_q    <= data_q[head_q];
                commit_rob_ind_q <= head_q;
            end
        end
    end

    assign alloc_ready    = alloc_rdy;
    assign alloc_idx      = tail_q;
    assign commit_valid   = commit_valid_q;
    assign commit_we      = commit_we_q;
    assign commit_rd      = commit_rd_q;
    assign commit_data    = commit_data_q;
    assign commit_rob_ind = commit_rob_ind_q;
    assign flush          = flush_q;
    assign count          = count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios then random traffic, all checked
// against a program-order queue model of the ROB.
module tb_reorder_buffer;
  import tomasulo_pkg::*;

  logic                 clk1;
  logic                 rst_n;
  logic                 alloc_valid;
  logic [3:0]           alloc_func;
  logic [REG_W-1:0]     alloc_rd;
  logic                 alloc_ready;
  logic [ROB_IDX_W-1:0] alloc_idx;
  logic                 cdb_valid;
  logic [ROB_IDX_W-1:0] cdb_rob_ind;
  logic [DATA_W-1:0]    cdb_data;
  logic                 cdb_mispredict;
  logic [ROB_IDX_W-1:0] lookup_idx;
  logic                 lookup_ready;
  logic [DATA_W-1:0]    lookup_data;
  logic                 commit_valid;
  logic                 commit_we;
  logic [REG_W-1:0]     commit_rd;
  logic [DATA_W-1:0]    commit_data;
  logic [ROB_IDX_W-1:0] commit_rob_ind;
  logic                 flush;
  logic [ROB_IDX_W:0]   count;

  reorder_buffer #(
    .DEPTH (ROB_DEPTH),
    .IDX_W (ROB_IDX_W),
    .DATA_W(DATA_W),
    .REG_W (REG_W)
  ) dut (
    .clk1          (clk1),
    .rst_n         (rst_n),
    .alloc_valid   (alloc_valid),
    .alloc_func    (alloc_func),
    .alloc_rd      (alloc_rd),
    .alloc_ready   (alloc_ready),
    .alloc_idx     (alloc_idx),
    .cdb_valid     (cdb_valid),
    .cdb_rob_ind   (cdb_rob_ind),
    .cdb_data      (cdb_data),
    .cdb_mispredict(cdb_mispredict),
    .lookup_idx    (lookup_idx),
    .lookup_ready  (lookup_ready),
    .lookup_data   (lookup_data),
    .commit_valid  (commit_valid),
    .commit_we     (commit_we),
    .commit_rd     (commit_rd),
    .commit_data   (commit_data),
    .commit_rob_ind(commit_rob_ind),
    .flush         (flush),
    .count         (count)
  );

  // ---------------- clock ----------------
  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [ROB_IDX_W-1:0] idx;
    rob_entry_t           e;
  } m_ent_t;

  m_ent_t            mq[$];
  int                m_tail;
  logic              sdone [ROB_DEPTH];
  logic [DATA_W-1:0] sdata [ROB_DEPTH];
  logic              e_cv, e_we, e_fl;
  logic [REG_W-1:0]  e_rd;
  logic [DATA_W-1:0] e_data;
  logic [ROB_IDX_W-1:0] e_ind;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      sdone[i] = 1'b0;
      sdata[i] = '0;
    end
    e_cv = 1'b0; e_we = 1'b0; e_fl = 1'b0;
    e_rd = '0; e_data = '0; e_ind = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic av, input logic [3:0] f, input logic [REG_W-1:0] rd,
                       input logic cv, input logic [ROB_IDX_W-1:0] ci,
                       input logic [DATA_W-1:0] cd, input logic cm,
                       input logic [ROB_IDX_W-1:0] li);
    alloc_valid    = av;
    alloc_func     = f;
    alloc_rd       = rd;
    cdb_valid      = cv;
    cdb_rob_ind    = ci;
    cdb_data       = cd;
    cdb_mispredict = cm;
    lookup_idx     = li;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next one.
  task automatic cycle();
    logic head_done, fl, rdy, exp_lr;
    logic [DATA_W-1:0] exp_ld;
    m_ent_t tmp;
    #1;
    head_done = (mq.size() > 0) && mq[0].e.done;
    fl  = head_done && is_branch(mq[0].e.func) && mq[0].e.mispredict;
    rdy = (mq.size() < ROB_DEPTH) && !fl;
    if (sdone[lookup_idx]) begin
      exp_lr = 1'b1; exp_ld = sdata[lookup_idx];
    end else if (cdb_valid && (cdb_rob_ind == lookup_idx)) begin
      exp_lr = 1'b1; exp_ld = cdb_data;
    end else begin
      exp_lr = 1'b0; exp_ld = '0;
    end
    check("alloc_ready", 32'(alloc_ready), 32'(rdy));
    check("alloc_idx", 32'(alloc_idx), 32'(m_tail));
    check("count_pre", 32'(count), 32'(mq.size()));
    check("lookup_ready", 32'(lookup_ready), 32'(exp_lr));
    check("lookup_data", 32'(lookup_data), 32'(exp_ld));

    e_cv = head_done;
    e_fl = fl;
    e_we = 1'b0;
    if (head_done) begin
      e_we   = writes_reg(mq[0].e.func) && !fl;
      e_rd   = mq[0].e.rd;
      e_data = mq[0].e.data;
      e_ind  = mq[0].idx;
    end
    if (fl) begin
      mq.delete();
      m_tail = 0;
      for (int i = 0; i < ROB_DEPTH; i++) sdone[i] = 1'b0;
    end else begin
      if (cdb_valid) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].idx == cdb_rob_ind) begin
            tmp = mq[i];
            tmp.e.done = 1'b1;
            tmp.e.data = cdb_data;
            if (is_branch(tmp.e.func)) tmp.e.mispredict = cdb_mispredict;
            mq[i] = tmp;
            sdone[cdb_rob_ind] = 1'b1;
            sdata[cdb_rob_ind] = cdb_data;
          end
        end
      end
      if (head_done) void'(mq.pop_front());
      if (alloc_valid && rdy) begin
        tmp.idx          = ROB_IDX_W'(m_tail);
        tmp.e.busy       = 1'b1;
        tmp.e.done       = 1'b0;
        tmp.e.mispredict = 1'b0;
        tmp.e.func       = alloc_func;
        tmp.e.rd         = alloc_rd;
        tmp.e.data       = '0;
        mq.push_back(tmp);
        sdone[m_tail] = 1'b0;
        m_tail = (m_tail + 1) % ROB_DEPTH;
      end
    end

    @(posedge clk1);
    #1;
    check("commit_valid", 32'(commit_valid), 32'(e_cv));
    check("commit_we", 32'(commit_we), 32'(e_we));
    check("flush", 32'(flush), 32'(e_fl));
    check("count_post", 32'(count), 32'(mq.size()));
    if (e_cv) begin
      check("commit_rd", 32'(commit_rd), 32'(e_rd));
      check("commit_data", 32'(commit_data), 32'(e_data));
      check("commit_rob_ind", 32'(commit_rob_ind), 32'(e_ind));
    end
    @(negedge clk1);
  endtask

  // Asserts reset partway through the low phase and checks outputs clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    idle();
    #1;
    check("rst_commit_valid", 32'(commit_valid), 32'(0));
    check("rst_commit_we", 32'(commit_we), 32'(0));
    check("rst_commit_rd", 32'(commit_rd), 32'(0));
    check("rst_commit_data", 32'(commit_data), 32'(0));
    check("rst_commit_rob_ind", 32'(commit_rob_ind), 32'(0));
    check("rst_flush", 32'(flush), 32'(0));
    check("rst_count", 32'(count), 32'(0));
    check("rst_alloc_ready", 32'(alloc_ready), 32'(1));
    check("rst_alloc_idx", 32'(alloc_idx), 32'(0));
    model_reset();
    @(posedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic alloc_one(input logic [3:0] f, input logic [REG_W-1:0] rd);
    drive(1'b1, f, rd, 1'b0, '0, '0, 1'b0, '0);
    cycle();
  endtask

  task automatic cdb_one(input logic [ROB_IDX_W-1:0] ci, input logic [DATA_W-1:0] cd,
                         input logic cm);
    drive(1'b0, 4'h0, '0, 1'b1, ci, cd, cm, '0);
    cycle();
  endtask

  task automatic drain();
    int guard;
    int pick;
    guard = 0;
    while (mq.size() > 0 && guard < 60) begin
      pick = -1;
      for (int i = 0; i < mq.size(); i++) begin
        if (pick < 0 && !mq[i].e.done) pick = i;
      end
      if (pick >= 0) drive(1'b0, 4'h0, '0, 1'b1, mq[pick].idx, DATA_W'($urandom), 1'b0, '0);
      else idle();
      cycle();
      guard++;
    end
    idle();
    check("drain_count", 32'(count), 32'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk1);
    do_reset();

    // single add round trip
    alloc_one(FUNC_ADD, 4'd3);
    cdb_one(3'd0, 16'h1234, 1'b0);
    idle();
    cycle();
    check("t1_commit_valid", 32'(commit_valid), 32'(1));
    check("t1_commit_we", 32'(commit_we), 32'(1));
    check("t1_commit_rd", 32'(commit_rd), 32'(3));
    check("t1_commit_data", 32'(commit_data), 32'h1234);
    check("t1_count", 32'(count), 32'(0));

    // fill, then wrap after the first commit
    do_reset();
    for (int i = 0; i < ROB_DEPTH; i++) alloc_one(FUNC_SUB, REG_W'(i));
    idle();
    #1;
    check("t2_count_full", 32'(count), 32'(8));
    check("t2_ready_full", 32'(alloc_ready), 32'(0));
    cdb_one(3'd0, 16'h00A5, 1'b0);
    drive(1'b1, FUNC_ADD, 4'd9, 1'b0, '0, '0, 1'b0, '0);
    #1;
    check("t2_ready_commit_cycle", 32'(alloc_ready), 32'(0));
    cycle();
    drive(1'b1, FUNC_ADD, 4'd9, 1'b0, '0, '0, 1'b0, '0);
    #1;
    check("t2_ready_after", 32'(alloc_ready), 32'(1));
    check("t2_wrap_idx", 32'(alloc_idx), 32'(0));
    cycle();
    drain();

    // out-of-order completion, in-order retirement
    do_reset();
    for (int i = 0; i < 3; i++) alloc_one(FUNC_MUL, REG_W'(i + 1));
    cdb_one(3'd2, 16'h0222, 1'b0);
    cdb_one(3'd1, 16'h0111, 1'b0);
    cdb_one(3'd0, 16'h0000, 1'b0);
    idle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t3_commit_valid", 32'(commit_valid), 32'(1));
      check("t3_commit_order", 32'(commit_rob_ind), 32'(k));
    end

    // store then mispredicted branch
    do_reset();
    alloc_one(FUNC_STORE, 4'd5);
    alloc_one(FUNC_BEQ, 4'd0);
    cdb_one(3'd0, 16'h0055, 1'b0);
    cdb_one(3'd1, 16'h0000, 1'b1);
    check("t4_store_valid", 32'(commit_valid), 32'(1));
    check("t4_store_we", 32'(commit_we), 32'(0));
    check("t4_store_ind", 32'(commit_rob_ind), 32'(0));
    drive(1'b1, FUNC_ADD, 4'd7, 1'b0, '0, '0, 1'b0, '0);
    #1;
    check("t4_ready_flush_cycle", 32'(alloc_ready), 32'(0));
    cycle();
    check("t4_flush", 32'(flush), 32'(1));
    check("t4_branch_valid", 32'(commit_valid), 32'(1));
    check("t4_branch_we", 32'(commit_we), 32'(0));
    check("t4_branch_ind", 32'(commit_rob_ind), 32'(1));
    check("t4_count", 32'(count), 32'(0));
    idle();
    #1;
    check("t4_ready_after", 32'(alloc_ready), 32'(1));
    check("t4_idx_after", 32'(alloc_idx), 32'(0));
    cycle();
    check("t4_flush_pulse", 32'(flush), 32'(0));

    // CDB forwarding to lookup, then stored value
    do_reset();
    alloc_one(FUNC_ADD, 4'd1);
    alloc_one(FUNC_ADD, 4'd2);
    drive(1'b0, 4'h0, '0, 1'b1, 3'd1, 16'h00FF, 1'b0, 3'd1);
    #1;
    check("t5_fwd_ready", 32'(lookup_ready), 32'(1));
    check("t5_fwd_data", 32'(lookup_data), 32'h00FF);
    cycle();
    drive(1'b0, 4'h0, '0, 1'b0, '0, '0, 1'b0, 3'd1);
    #1;
    check("t5_stored_ready", 32'(lookup_ready), 32'(1));
    check("t5_stored_data", 32'(lookup_data), 32'h00FF);
    cycle();
    drive(1'b0, 4'h0, '0, 1'b0, '0, '0, 1'b0, 3'd0);
    #1;
    check("t5_pending_ready", 32'(lookup_ready), 32'(0));
    check("t5_pending_data", 32'(lookup_data), 32'(0));
    cycle();
    drain();

    // reset in the middle of traffic, with a commit pending
    do_reset();
    for (int i = 0; i < 5; i++) alloc_one(FUNC_LOAD, REG_W'(i));
    cdb_one(3'd0, 16'hBEEF, 1'b0);
    do_reset();
    idle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t6_no_commit", 32'(commit_valid), 32'(0));
    end

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [ROB_IDX_W-1:0] ci;
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        ci = mq[$urandom_range(0, mq.size() - 1)].idx;
      else
        ci = ROB_IDX_W'($urandom_range(0, ROB_DEPTH - 1));
      drive($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), REG_W'($urandom),
            1'($urandom_range(0, 1)), ci, DATA_W'($urandom),
            $urandom_range(0, 7) == 0, ROB_IDX_W'($urandom_range(0, ROB_DEPTH - 1)));
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
